// File: rtl/spi_xfer_queue_if.sv
// ----------------------------------------------------------------------------
// spi_xfer_queue_if
// Bundles the spi_xfer_queue bus signals: TX write port, RX read port,
// error clear, the spi_master control/data pair and the status outputs.
//   slave  : seen by spi_xfer_queue (drives Start/TxData/status/RX head)
//   master : seen by the environment (drives writes, pops, Done/RxData)
// ----------------------------------------------------------------------------
interface spi_xfer_queue_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] WrData;
    logic                  WrValid;
    logic                  WrReady;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdValid;
    logic                  RdReady;
    logic                  ClrErr;
    logic                  Start;
    logic [DATA_WIDTH-1:0] TxData;
    logic                  Done;
    logic [DATA_WIDTH-1:0] RxData;
    logic                  Busy;
    logic                  Timeout;
    logic [LW-1:0]         TxLevel;
    logic [LW-1:0]         RxLevel;

    modport slave (
        input  WrData, WrValid, RdReady, ClrErr, Done, RxData,
        output WrReady, RdData, RdValid, Start, TxData, Busy, Timeout,
               TxLevel, RxLevel
    );

    modport master (
        output WrData, WrValid, RdReady, ClrErr, Done, RxData,
        input  WrReady, RdData, RdValid, Start, TxData, Busy, Timeout,
               TxLevel, RxLevel
    );
endinterface

// File: rtl/spi_xfer_queue.sv
// ----------------------------------------------------------------------------
// spi_xfer_queue
// Feeds spi_master: words written into a TX FIFO are launched one per
// transfer (Start pulse + held TxData), received words are captured on the
// rising edge of Done into an RX FIFO. Transfers are separated by a
// programmable gap and a watchdog abandons a transfer that never completes.
// Ports:
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : spi_xfer_queue_if.slave (write/read ports, master link, status)
// ----------------------------------------------------------------------------
module spi_xfer_queue #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic              Clk,
    input  logic              Reset_n,
    spi_xfer_queue_if.slave   bus
);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned LW      = PW + 1;
    localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]            r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_start, r_busy, r_timeout, r_done_q;
    logic [DATA_WIDTH-1:0] r_tx_data;

    logic [DATA_WIDTH-1:0] r_tx_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_mem [DEPTH];
    logic [PW-1:0]         r_tx_wr_ptr, r_tx_rd_ptr, r_rx_wr_ptr, r_rx_rd_ptr;
    logic [LW-1:0]         r_tx_level, r_rx_level;

    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic w_tx_full, w_rx_full, w_rx_empty;
    logic w_done_rise, w_launch_ok, w_to_set;

    assign w_tx_full   = (r_tx_level == LW'(DEPTH));
    assign w_rx_full   = (r_rx_level == LW'(DEPTH));
    assign w_rx_empty  = (r_rx_level == '0);
    assign w_tx_push   = bus.WrValid && !w_tx_full;
    assign w_rx_pop    = bus.RdReady && !w_rx_empty;
    assign w_done_rise = bus.Done && !r_done_q;
    // Launch only when nothing is in flight, so RX not full is enough headroom
    assign w_launch_ok = (r_tx_level != '0) && !w_rx_full;

    assign bus.WrReady = !w_tx_full;
    assign bus.RdValid = !w_rx_empty;
    assign bus.RdData  = w_rx_empty ? '0 : r_rx_mem[r_rx_rd_ptr];
    assign bus.TxLevel = r_tx_level;
    assign bus.RxLevel = r_rx_level;
    assign bus.Start   = r_start;
    assign bus.TxData  = r_tx_data;
    assign bus.Busy    = r_busy;
    assign bus.Timeout = r_timeout;

    // FSM state, shared counter and registered Start/Busy
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_start <= (w_state_nxt == S_START);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Next state; the GAP exit may launch directly so a zero gap costs one cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_pop    = 1'b0;
        w_rx_push   = 1'b0;
        w_to_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch_ok) begin
                    w_state_nxt = S_START;
                    w_tx_pop    = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                if (w_done_rise) begin
                    w_rx_push   = 1'b1;
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == CW'(GAP_CYCLES)) begin
                    w_cnt_nxt = '0;
                    if (w_launch_ok) begin
                        w_state_nxt = S_START;
                        w_tx_pop    = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO pointers/levels, launched word, Done history and sticky timeout
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_tx_level  <= '0;
            r_rx_level  <= '0;
            r_tx_data   <= '0;
            r_done_q    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done_q <= bus.Done;
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + PW'(1);
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + PW'(1);
                r_tx_data   <= r_tx_mem[r_tx_rd_ptr];
            end
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + PW'(1);
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + PW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_level <= r_tx_level + LW'(1);
                2'b01:   r_tx_level <= r_tx_level - LW'(1);
                default: r_tx_level <= r_tx_level;
            endcase
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_level <= r_rx_level + LW'(1);
                2'b01:   r_rx_level <= r_rx_level - LW'(1);
                default: r_rx_level <= r_rx_level;
            endcase
            if (w_to_set)         r_timeout <= 1'b1;
            else if (bus.ClrErr)  r_timeout <= 1'b0;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge Clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= bus.WrData;
        if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= bus.RxData;
    end
endmodule
